// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter and issue sequencer sharing one combinational ALU between two requesters.
// One op in flight: accept, drive ALU pins, wait SETTLE cycles, sample result, hand it back.
module alu_req_arbiter #(
  parameter int OPW    = 3,
  parameter int CTW    = 3,
  parameter int RESW   = 6,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [OPW-1:0]  req0_a,
  input  logic [OPW-1:0]  req0_b,
  input  logic [CTW-1:0]  req0_op,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [OPW-1:0]  req1_a,
  input  logic [OPW-1:0]  req1_b,
  input  logic [CTW-1:0]  req1_op,
  output logic [OPW-1:0]  alu_a,
  output logic [OPW-1:0]  alu_b,
  output logic [CTW-1:0]  alu_ctrl,
  input  logic [RESW-1:0] alu_res,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [RESW-1:0] rsp_data,
  output logic            rsp_id,
  output logic            busy
);

  localparam int CW = 4;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  typedef struct packed {
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
    logic [CTW-1:0] op;
  } req_t;

  state_t          state, state_nx;
  req_t [1:0]      req;
  logic [1:0]      vld;
  logic            last_id;
  logic            gnt_id;
  logic            accept;
  logic            settled;
  logic [CW-1:0]   cnt;

  assign req[0]  = {req0_a, req0_b, req0_op};
  assign req[1]  = {req1_a, req1_b, req1_op};
  assign vld     = {req1_valid, req0_valid};

  // On a tie the requester that did not win last time goes next.
  assign gnt_id  = (&vld) ? ~last_id : vld[1];
  assign accept  = (state == IDLE) && ena && (|vld);
  assign settled = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)                 state_nx = EXEC;
      EXEC:    if (settled)                state_nx = RESP;
      RESP:    if (rsp_valid && rsp_ready) state_nx = IDLE;
      default:                             state_nx = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = accept && !gnt_id;
    req1_ready = accept &&  gnt_id;
    busy       = (state != IDLE);
  end

  // ALU pins keep the last issued op after completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_ctrl  <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
      last_id   <= 1'b1;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          alu_a    <= req[gnt_id].a;
          alu_b    <= req[gnt_id].b;
          alu_ctrl <= req[gnt_id].op;
          rsp_id   <= gnt_id;
          last_id  <= gnt_id;
          cnt      <= CW'(SETTLE - 1);
        end
        EXEC: begin
          if (settled) begin
            rsp_data  <= alu_res;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
